// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Multi-cycle execute stage placed downstream of the 8x16
//               register file. It captures two source operands and a
//               destination index on an accepted start. It computes
//               ADD / AND / NOT / PASSA in one cycle, or MUL by iterative
//               shift-add. It then drives the register-file write port for
//               exactly one cycle and produces LC-3 style NZP condition codes.
//
//               Optional feature macro: ALU_MUL_EN
//                 defined   : MUL state, iteration counter and accumulator are
//                             built in. Op=100 takes WIDTH+1 cycles to writeback.
//                 undefined : Op=100 decodes as PASSA with single-cycle timing.
//
// Ports       : clk     in   rising-edge clock
//               rst_n   in   asynchronous active-low reset
//               start   in   operation request, honoured only while ready=1
//               op      in   3-bit opcode (000 ADD, 001 AND, 010 NOT,
//                            011 PASSA, 100 MUL, others PASSA)
//               a, b    in   WIDTH-bit source operands (SR1_Out / SR2_Out)
//               dr_in   in   destination register index
//               ready   out  high only while idle
//               load    out  one-cycle register-file write strobe
//               dr_out  out  destination index, valid while load=1
//               result  out  write data, held until the next writeback
//               nzp     out  {N,Z,P} of the last written result
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       dr_in,
    output logic             ready,
    output logic             load,
    output logic [2:0]       dr_out,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;

    localparam logic [2:0] NZP_ZERO = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;

    logic             accept;
    logic             go_mul;
    logic [WIDTH-1:0] alu_res;

    // Exactly one bit is set: negative takes priority over zero by
    // construction, because a zero value never has its MSB set.
    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        logic [2:0] f;
        if (v[WIDTH-1])     f = 3'b100;
        else if (v == '0)   f = 3'b010;
        else                f = 3'b001;
        return f;
    endfunction

    assign accept = (state == S_IDLE) && start;

`ifdef ALU_MUL_EN
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] cnt;
    // Only the low WIDTH bits of the product are written back. Bits shifted
    // past WIDTH never affect those bits, so the accumulator is WIDTH wide.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;
    logic             mul_last;

    assign partial  = b_q[cnt] ? (a_q << cnt) : '0;
    assign acc_sum  = acc + partial;
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));
    assign go_mul   = (op == OP_MUL);
`else
    assign go_mul   = 1'b0;
`endif

    // Single-cycle ALU. Op=100 only reaches here when MUL is not built in,
    // and in that case it falls through to PASSA with every other unused code.
    always_comb begin
        alu_res = a_q;
        case (op_q)
            OP_ADD:   alu_res = a_q + b_q;
            OP_AND:   alu_res = a_q & b_q;
            OP_NOT:   alu_res = ~a_q;
            OP_PASSA: alu_res = a_q;
            default:  alu_res = a_q;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = go_mul ? S_MUL : S_EXEC;
            S_EXEC: state_next = S_WB;
`ifdef ALU_MUL_EN
            S_MUL:  if (mul_last) state_next = S_WB;
`else
            S_MUL:  state_next = S_IDLE;
`endif
            S_WB:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE);
        load  = (state == S_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            dr_out <= '0;
            result <= '0;
            nzp    <= NZP_ZERO;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                op_q   <= op;
                dr_out <= dr_in;
            end
            if (state == S_EXEC) begin
                result <= alu_res;
                nzp    <= nzp_of(alu_res);
            end
`ifdef ALU_MUL_EN
            if ((state == S_MUL) && mul_last) begin
                result <= acc_sum;
                nzp    <= nzp_of(acc_sum);
            end
`endif
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            cnt <= '0;
            acc <= '0;
        end else if (state == S_MUL) begin
            cnt <= cnt + 1'b1;
            acc <= acc_sum;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit. It exercises
//               reset state, each opcode, NZP boundaries, writeback latency,
//               operand capture with start held high, and reset dropping an
//               in-flight operation. It follows ALU_MUL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int WIDTH = 16;
`ifdef ALU_MUL_EN
    localparam int MUL_LAT = WIDTH;
`else
    localparam int MUL_LAT = 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       dr_in;
    logic             ready;
    logic             load;
    logic [2:0]       dr_out;
    logic [WIDTH-1:0] result;
    logic [2:0]       nzp;

    int tests_run;
    int tests_failed;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .dr_in  (dr_in),
        .ready  (ready),
        .load   (load),
        .dr_out (dr_out),
        .result (result),
        .nzp    (nzp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},  32'(ready),  32'd1);
        check({tag, "_load"},   32'(load),   32'd0);
        check({tag, "_result"}, 32'(result), 32'h0);
        check({tag, "_dr"},     32'(dr_out), 32'd0);
        check({tag, "_nzp"},    32'(nzp),    32'b010);
    endtask

    // Issue one operation and follow it to writeback. lat is the number of
    // rising edges after the acceptance edge at which load is first seen high.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [2:0] d, input logic [WIDTH-1:0] er,
                          input logic [2:0] en, input int lat);
        int cyc;
        @(negedge clk);
        check({tag, "_rdy_pre"}, 32'(ready), 32'd1);
        start = 1'b1; op = o; a = av; b = bv; dr_in = d;
        @(posedge clk); #1;
        // Scramble the inputs so that any late sampling shows up.
        start = 1'b0; a = ~av; b = ~bv; dr_in = ~d; op = ~o;
        check({tag, "_rdy_busy"}, 32'(ready), 32'd0);
        cyc = 1;
        @(posedge clk); #1;
        while (!load && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"},    32'(cyc),    32'(lat));
        check({tag, "_dr"},     32'(dr_out), 32'(d));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_nzp"},    32'(nzp),    32'(en));
        @(posedge clk); #1;
        check({tag, "_load_1cyc"}, 32'(load),  32'd0);
        check({tag, "_rdy_post"},  32'(ready), 32'd1);
        check({tag, "_hold"},      32'(result), 32'(er));
    endtask

    int load_cnt;
    int load_edge [3];
    logic [WIDTH-1:0] load_res [3];

    initial begin
        tests_run = 0;
        tests_failed = 0;
        start = 1'b0; op = 3'b000; a = '0; b = '0; dr_in = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst_init");
        @(negedge clk); rst_n = 1'b1;

        // Core opcodes and NZP boundaries.
        run_op("add_ovf",  3'b000, 16'h7FFF, 16'h0001, 3'd3, 16'h8000, 3'b100, 1);
        run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 3'd5, 16'h0000, 3'b010, 1);
        run_op("not",      3'b010, 16'h00FF, 16'h1234, 3'd1, 16'hFF00, 3'b100, 1);
        run_op("and",      3'b001, 16'hF0F0, 16'h0FF0, 3'd7, 16'h00F0, 3'b001, 1);
        run_op("passa",    3'b011, 16'h8001, 16'h5555, 3'd2, 16'h8001, 3'b100, 1);
        run_op("op101",    3'b101, 16'h0042, 16'h7777, 3'd6, 16'h0042, 3'b001, 1);

`ifdef ALU_MUL_EN
        run_op("mul",      3'b100, 16'h0123, 16'h0045, 3'd4, 16'h4E6F, 3'b001, MUL_LAT);
        run_op("mul_zero", 3'b100, 16'h1000, 16'h0010, 3'd3, 16'h0000, 3'b010, MUL_LAT);
`else
        run_op("op100",    3'b100, 16'h0123, 16'h0045, 3'd4, 16'h0123, 3'b001, MUL_LAT);
`endif

        // Reset in the middle of a sequence, with a nonzero result present.
        run_op("pre_rst",  3'b000, 16'h7FFF, 16'h0001, 3'd3, 16'h8000, 3'b100, 1);
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'h0001; b = 16'h0001; dr_in = 3'd6;
        @(posedge clk); #1;
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_async");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_state("rst_rel");

        // Start held high with operands changing while busy. Loads are
        // expected at edges 1, 4 and 7 after the first acceptance.
        load_cnt = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'd1; b = 16'd2; dr_in = 3'd1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin a = 16'd100; b = 16'd200; end
            if (e == 4) begin a = 16'd5;   b = 16'd6;   end
            if (load) begin
                if (load_cnt < 3) begin
                    load_edge[load_cnt] = e - 1;
                    load_res[load_cnt]  = result;
                end
                load_cnt++;
            end
            if (e == 7) start = 1'b0;
        end
        check("b2b_count", 32'(load_cnt), 32'd3);
        check("b2b_edge0", 32'(load_edge[0]), 32'd1);
        check("b2b_edge1", 32'(load_edge[1]), 32'd4);
        check("b2b_edge2", 32'(load_edge[2]), 32'd7);
        check("b2b_res0",  32'(load_res[0]),  32'd3);
        check("b2b_res1",  32'(load_res[1]),  32'd300);
        check("b2b_res2",  32'(load_res[2]),  32'd11);

        // Reset while the operation is in flight (counter=8 for MUL).
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 16'h0123; b = 16'h0045; dr_in = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef ALU_MUL_EN
        repeat (8) @(posedge clk);
        #1;
`endif
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        load_cnt = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (load) load_cnt++;
        end
        check("drop_load", 32'(load_cnt), 32'd0);
        check("drop_nzp",  32'(nzp),      32'b010);
        check("drop_res",  32'(result),   32'h0);
        run_op("post_drop", 3'b000, 16'h0002, 16'h0003, 3'd5, 16'h0005, 3'b001, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute stage sitting directly downstream of the 8×16 register file. It captures the two source-register read values and a destination-register index, computes the result over one or more cycles, and drives the register file's write port (load strobe, destination index, write data) for exactly one cycle. It also produces LC-3-style NZP condition codes. Start/Ready handshake with the control FSM.

## Interface
- WIDTH, 16, datapath width; multiply iteration count equals WIDTH
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low; all state cleared immediately while low
- Start  in  1  operation request; accepted only on an edge where Ready=1
- Op  in  3  000 ADD, 001 AND, 010 NOT(A), 011 PASSA, 100 MUL (ALU_MUL_EN only); others decode as PASSA
- A  in  WIDTH  operand A, driven from register file SR1_Out
- B  in  WIDTH  operand B, driven from register file SR2_Out
- DR_In  in  3  destination register index for this operation
- Ready  out  1  high only in IDLE
- Load  out  1  one-cycle write strobe to register file Load
- DR_Out  out  3  destination index to register file DR_In; valid while Load=1
- Result  out  WIDTH  write data to register file In; held until next writeback
- NZP  out  3  {N,Z,P} of last written Result; exactly one bit set

## Operation
- States: IDLE, EXEC, MUL, WB.
- IDLE: Ready=1. On an edge with Start=1: register A, B, Op, DR_In. Next state is MUL if Op=100 and ALU_MUL_EN is defined, otherwise EXEC.
- EXEC: one cycle. Compute and register Result and NZP. Next state is WB.
  - ADD: A+B modulo 2^WIDTH; carry discarded.
  - AND: A&B.
  - NOT: ~A; B ignored.
  - PASSA: A.
- MUL: shift-add multiply. Iteration counter runs 0..WIDTH-1.
  - Each cycle: if captured B bit[i]=1, then acc += A<<i.
  - After iteration WIDTH-1: Result and NZP register the low WIDTH bits of acc; upper bits are discarded. Next state is WB.
- WB: Load=1 and DR_Out = captured DR. Next state is IDLE unconditionally.
- NZP rule: N=Result[WIDTH-1]; Z=(Result==0); P=neither.
- Start outside IDLE is ignored; no queuing and no error.
- A, B and DR_In are sampled only at acceptance. Later changes, including the register file being rewritten, have no effect on the operation in flight.
- Reset low in any state:
  - state goes to IDLE and Ready=1;
  - Load=0, Result=0, DR_Out=0, NZP=3'b010, counter and acc cleared;
  - an in-flight operation is dropped with no writeback.

## Timing
- Edge numbering: acceptance edge is E0.
- Non-MUL ops:
  - EXEC during E0–E1; Result and NZP valid after E1.
  - Load=1 between E1 and E2. The register file writes at E2.
  - Ready=1 after E2, so the next Start is accepted at E3 at the earliest.
- MUL: Result valid after E16 (WIDTH=16). Load=1 between E16 and E17; Ready=1 after E17.
- Load is never high on two consecutive cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset deassertion takes effect at the next rising edge. Start is honoured on the first edge with Reset high.

## Configuration
- ALU_MUL_EN defined: MUL state, counter and accumulator are present; Op=100 takes WIDTH+1 cycles to writeback.
- ALU_MUL_EN undefined: MUL logic is not compiled in; Op=100 decodes as PASSA with non-MUL timing.

## Test plan
- Reset low mid-sequence, then high → Ready=1, Load=0, Result=0x0000, DR_Out=0, NZP=010.
- ADD A=0x7FFF, B=0x0001, DR=3 → Load pulses once 2 cycles after acceptance with DR_Out=3, Result=0x8000, NZP=100. Repeat with A=0xFFFF, B=0x0001 → Result=0x0000, NZP=010.
- NOT A=0x00FF → Result=0xFF00, NZP=100. AND 0xF0F0 & 0x0FF0 → Result=0x00F0, NZP=001.
- MUL (ALU_MUL_EN) A=0x0123, B=0x0045 → Load exactly 17 cycles after acceptance, Result=0x4E6F, NZP=001. A=0x1000, B=0x0010 → Result=0x0000, NZP=010. Without the macro, Op=100 with A=0x0123 → Result=0x0123 after 2 cycles.
- Start held high continuously, with A and B changed during EXEC/MUL → operations run back-to-back with one Load per op. Each Result uses the operands captured at acceptance; no Start is accepted while Ready=0.
- Reset asserted during the MUL iteration at counter=8 → Load never pulses, NZP=010, and a subsequent ADD completes normally.
